// File: rtl/ex_div_sequencer_if.sv
// ex_div_sequencer_if: execute-stage handshake between the pipeline and the
// RV32M divide sequencer.
//   master (pipeline): drives start, op, rs1, rs2, flush; observes stall,
//                      valid, result_sel, result.
//   slave  (divider) : the reverse.
// XLEN must match the XLEN of the ex_div_sequencer instance it connects to.
interface ex_div_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;       // divide instruction present in EX
  logic [1:0]      op;          // 00 DIV, 01 DIVU, 10 REM, 11 REMU
  logic [XLEN-1:0] rs1;         // dividend
  logic [XLEN-1:0] rs2;         // divisor
  logic            flush;       // synchronous abort
  logic            stall;       // freeze IF/ID/EX registers
  logic            valid;       // result valid this cycle
  logic            result_sel;  // EX result mux: 0 = ALU, 1 = divider
  logic [XLEN-1:0] result;      // quotient or remainder

  modport master (
    output start, op, rs1, rs2, flush,
    input  stall, valid, result_sel, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output stall, valid, result_sel, result
  );
endinterface

// File: rtl/ex_div_sequencer.sv
// ex_div_sequencer: multi-cycle controller and radix-2 restoring datapath for
// RV32M DIV/DIVU/REM/REMU in the execute stage. One operation at a time; the
// pipeline is stalled while the XLEN iterations run, then the result is
// presented for exactly one cycle with result_sel steering the EX result mux.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (drops the operation in flight)
//   bus      ex_div_sequencer_if.slave: start/op/rs1/rs2/flush in,
//            stall/valid/result_sel/result out
//
// Build option:
//   EX_DIV_FAST_PATH_EN  when defined, a divisor of magnitude 1 and a dividend
//                        magnitude smaller than the divisor magnitude finish in
//                        one edge. Results are identical either way.
module ex_div_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               reset_n,
  ex_div_sequencer_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinInt  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN:0]   rem_q;      // one extra bit so the subtract borrow is visible
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] result_q;
  logic            rem_sel_q;  // 1: REM/REMU, 0: DIV/DIVU
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            valid_q;

  // Operand decode for the accepting cycle
  logic            signed_op, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, overflow, fast_unit, fast_small, special;
  logic [XLEN-1:0] sp_quo, sp_rem, sp_val;
  // Iteration step
  logic [XLEN+1:0] rem_shift, diff;
  logic            borrow;
  // Sign correction
  logic [XLEN-1:0] fix_raw, fix_val;
  logic            fix_neg;

  always_comb begin
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.rs1[XLEN-1];
    b_neg     = signed_op & bus.rs2[XLEN-1];
    // -MinInt wraps to MinInt, which read unsigned is 2^(XLEN-1)
    a_abs     = a_neg ? -bus.rs1 : bus.rs1;
    b_abs     = b_neg ? -bus.rs2 : bus.rs2;
    div_zero  = (bus.rs2 == '0);
    overflow  = signed_op && (bus.rs1 == MinInt) && (bus.rs2 == '1);
`ifdef EX_DIV_FAST_PATH_EN
    fast_unit  = (b_abs == XLEN'(1));
    fast_small = (a_abs < b_abs);
`else
    fast_unit  = 1'b0;
    fast_small = 1'b0;
`endif
    special = div_zero | overflow | fast_unit | fast_small;

    // Priority matters: divide-by-zero and overflow override the fast cases
    if (div_zero) begin
      sp_quo = '1;
      sp_rem = bus.rs1;
    end else if (overflow) begin
      sp_quo = MinInt;
      sp_rem = '0;
    end else if (fast_unit) begin
      sp_quo = b_neg ? -bus.rs1 : bus.rs1;
      sp_rem = '0;
    end else begin
      sp_quo = '0;
      sp_rem = bus.rs1;
    end
    sp_val = bus.op[1] ? sp_rem : sp_quo;

    // rem_q never exceeds XLEN bits between steps, so its top bit is zero
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {2'b00, div_q};
    borrow    = diff[XLEN+1];

    fix_raw = rem_sel_q ? rem_q[XLEN-1:0] : quo_q;
    fix_neg = rem_sel_q ? neg_rem_q : neg_quo_q;
    fix_val = fix_neg ? -fix_raw : fix_raw;
  end

  // Stall drops with flush (and under reset) so the pipeline can move on
  assign bus.stall = reset_n & ~bus.flush &
                     (((state_q == StIdle) & bus.start) |
                      (state_q == StCalc) | (state_q == StFix));

  // valid and result_sel are both high only in DONE
  assign bus.valid      = valid_q;
  assign bus.result_sel = valid_q;
  assign bus.result     = result_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.flush) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              rem_sel_q <= bus.op[1];
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              if (special) begin
                result_q <= sp_val;
                valid_q  <= 1'b1;
                state_q  <= StDone;
              end else begin
                rem_q   <= '0;
                quo_q   <= a_abs;
                div_q   <= b_abs;
                cnt_q   <= '0;
                state_q <= StCalc;
              end
            end
          end
          StCalc: begin
            rem_q <= borrow ? rem_shift[XLEN:0] : diff[XLEN:0];
            quo_q <= {quo_q[XLEN-2:0], ~borrow};
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
              state_q <= StFix;
            end
          end
          StFix: begin
            result_q <= fix_val;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
          StDone: begin
            // start still reflects the same instruction here
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/ex_div_sequencer.md
Name: ex_div_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the RV32M divide and remainder instructions (DIV, DIVU, REM, REMU) in the execute stage.
- Accepts one operation at a time and stalls the pipeline while the quotient or remainder is computed with a radix-2 restoring algorithm.
- Drives the select line of the execute-stage 32-bit result mux so the final value replaces the ALU output for exactly one cycle.

Parameters:
- XLEN, 32: operand and result width; the iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  divide instruction present in EX; sampled only in IDLE
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- rs1  in  XLEN  dividend
- rs2  in  XLEN  divisor
- flush  in  1  synchronous abort from hazard/branch logic
- stall  out  1  freeze IF/ID/EX pipeline registers
- valid  out  1  result valid this cycle
- result_sel  out  1  execute result mux select: 0 = ALU, 1 = divider
- result  out  XLEN  quotient or remainder

Behaviour:
- Reset: reset_n low asynchronously forces state IDLE, clears all internal registers, and sets stall=0, valid=0, result_sel=0, result=0. This applies mid-operation and discards the operation in flight.
- States:
  - IDLE: waiting for start.
  - CALC: iterating; iteration counter runs 0..XLEN-1.
  - FIX: sign correction of the raw quotient/remainder.
  - DONE: presenting the result for one cycle.
- IDLE with start=1 and flush=0, at the clock edge:
  - Latch op and sign flags.
  - Divisor==0 goes directly to DONE: quotient=all ones (0xFFFFFFFF), remainder=rs1.
  - Signed op with rs1=0x80000000 and rs2=0xFFFFFFFF goes directly to DONE: quotient=0x80000000, remainder=0.
  - Otherwise load |rs1|, |rs2| (raw values for unsigned ops) and go to CALC, counter=0.
- CALC, each edge: shift remainder:quotient left by one; subtract the divisor when the result is non-negative; set the quotient LSB. After XLEN iterations (counter==XLEN-1), go to FIX.
- FIX, one edge:
  - Quotient is negated if the signed op has differing operand signs.
  - Remainder takes the dividend's sign for signed ops.
  - Go to DONE.
- DONE:
  - valid=1, result_sel=1, result = quotient (DIV/DIVU) or remainder (REM/REMU).
  - Next edge returns to IDLE unconditionally. start is ignored in DONE because it still reflects the same instruction.
- Latency:
  - Normal path: valid is high in the cycle after XLEN+2 edges counted from the accepting edge (XLEN edges in CALC, then FIX, then DONE).
  - Special cases: valid is high in the cycle after 1 edge.
- stall (combinational) = (state==IDLE && start && !flush) || state==CALC || state==FIX. stall is low in DONE so the pipeline advances on the same edge the result is captured.
- Back-to-back divides: the next instruction reaches EX as the block re-enters IDLE and is accepted there. This gives one DONE→IDLE gap per operation.
- flush=1 in any state: next edge goes to IDLE. No valid is produced for the aborted operation; stall drops combinationally in the same cycle.
- Outside DONE: valid=0, result_sel=0; result holds its last value.
- Signed arithmetic rules:
  - Absolute values use two's complement.
  - |0x80000000| is treated as the unsigned value 2^31.
  - Internal remainder register is XLEN+1 bits wide so the subtraction borrow is visible.

Optional Feature:
- Macro EX_DIV_FAST_PATH_EN.
- When defined, two more cases in IDLE go directly to DONE with 1-edge latency:
  - Divisor magnitude 1: quotient = signed/unsigned rs1 with the correct sign, remainder=0.
  - Unsigned |rs1| < |rs2|: quotient=0, remainder=rs1.
- When undefined, these cases take the full XLEN+2 path. Results are identical in both builds; only latency differs.

Test Plan:
- DIVU rs1=100, rs2=7 → stall for XLEN+2 cycles (including the accepting cycle), then valid=1, result_sel=1, result=14; REMU with the same operands → result=2.
- DIV rs1=-100 (0xFFFFFF9C), rs2=7 → result=0xFFFFFFF2 (-14); REM → 0xFFFFFFFE (-2).
- DIV rs2=0, rs1=0x12345678 → valid after 1 edge, result=0xFFFFFFFF; REM with the same operands → 0x12345678.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → result=0x80000000 after 1 edge; REM → 0.
- Start DIVU 1000/10, then assert flush at iteration 5 → no valid pulse, stall=0 that cycle, state IDLE next edge. Repeat with reset_n pulsed low mid-CALC → all outputs 0 immediately.
- DIVU 5/9: with EX_DIV_FAST_PATH_EN, valid after 1 edge; without it, after XLEN+2 edges. Both give result=0 (DIVU), 5 (REMU).
